// File: rtl/mem_store_unit.sv
// Store unit: serialises 1/2/4-byte stores from the reorder buffer into byte-wide RAM writes.
// Optional IO back-pressure stall is compiled in with `define MEM_IO_STALL_EN.
module mem_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rob_save_data,
  input  logic [2:0]  in_rob_size,
  input  logic [31:0] in_rob_address,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_save_done,
  input  logic        in_io_buffer_full,
  output logic [31:0] out_ram_a,
  output logic [7:0]  out_ram_dout,
  output logic        out_ram_wr,
  output logic        out_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        size_ok;
  logic        last_byte;
  logic        stall;
  logic        in_write;

  assign size_ok   = (in_rob_size == 3'd1) || (in_rob_size == 3'd2) || (in_rob_size == 3'd4);
  assign last_byte = ({1'b0, cnt} == (size_q - 3'd1));
  assign in_write  = (state == WRITE);

`ifdef MEM_IO_STALL_EN
  // IO space lives at address[17:16] == 2'b11; hold the byte until the IO buffer drains.
  assign stall = in_write && (addr_q[17:16] == 2'b11) && in_io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = in_io_buffer_full;
  assign stall          = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      size_q <= 3'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (in_rob_save_data) begin
            if (size_ok) begin
              addr_q <= in_rob_address;
              data_q <= in_rob_data;
              size_q <= in_rob_size;
              cnt    <= 2'd0;
              state  <= WRITE;
            end else begin
              state <= DONE;
            end
          end
        end
        WRITE: begin
          if (!stall) begin
            if (last_byte) state <= DONE;
            else           cnt   <= cnt + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    out_ram_a    = 32'd0;
    out_ram_dout = 8'd0;
    if (in_write) begin
      out_ram_a = addr_q + {30'd0, cnt};
      case (cnt)
        2'd0:    out_ram_dout = data_q[7:0];
        2'd1:    out_ram_dout = data_q[15:8];
        2'd2:    out_ram_dout = data_q[23:16];
        default: out_ram_dout = data_q[31:24];
      endcase
    end
  end

  // Strobes are gated by rdy so a frozen cycle neither writes nor consumes the done pulse.
  assign out_ram_wr        = in_write && rdy && !stall;
  assign out_rob_save_done = (state == DONE) && rdy;
  assign out_busy          = (state != IDLE);

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 rdy  input  1  global enable; 0 freezes all state.
REQ-004 in_rob_save_data  input  1  one-cycle store request pulse from reorder buffer.
REQ-005 in_rob_size  input  3  store byte count; legal values 1, 2, 4.
REQ-006 in_rob_address  input  32  byte address of least-significant byte.
REQ-007 in_rob_data  input  32  store data, little-endian, low bytes used.
REQ-008 out_rob_save_done  output  1  one-cycle completion pulse to reorder buffer.
REQ-009 in_io_buffer_full  input  1  external IO buffer full indication.
REQ-010 out_ram_a  output  32  RAM byte address.
REQ-011 out_ram_dout  output  8  RAM write byte.
REQ-012 out_ram_wr  output  1  RAM write strobe; 1 = write out_ram_dout at out_ram_a this cycle.
REQ-013 out_busy  output  1  1 whenever state != IDLE; load path must not drive RAM.

Function
REQ-014 States SHALL be IDLE, WRITE, DONE; 2-bit encoded.
REQ-015 IDLE: on in_rob_save_data=1 with size 1/2/4 SHALL latch address, data, size, clear byte counter to 0, go WRITE.
REQ-016 IDLE: request with any other size SHALL go DONE with no RAM write.
REQ-017 WRITE: each active cycle SHALL drive out_ram_a = base + k, out_ram_dout = data[8k+7:8k], out_ram_wr = 1 for byte k, k = 0..size-1.
REQ-018 Address increment SHALL be 32-bit modulo (0xFFFFFFFF + 1 wraps to 0).
REQ-019 Byte-count-N store: request edge E0; byte k visible in cycle after E(k); DONE entered at E(N); out_rob_save_done=1 for exactly one cycle after E(N); IDLE at E(N+1).
REQ-020 DONE: out_ram_wr = 0, out_rob_save_done = 1; unconditional return to IDLE next active edge.
REQ-021 Requests arriving in WRITE or DONE SHALL be ignored; no queueing.
REQ-022 rdy=0: state, counter, latched fields hold; out_ram_wr forced 0; out_rob_save_done held 0 and its pulse deferred to the first rdy=1 cycle.
REQ-023 out_ram_wr SHALL never be 1 outside WRITE.
REQ-024 A store in progress SHALL complete regardless of branch flush activity elsewhere.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, counter 0, out_ram_wr 0, out_rob_save_done 0, out_busy 0, out_ram_a 0, out_ram_dout 0.
REQ-026 Reset mid-WRITE SHALL abandon the store: no further bytes written, no done pulse.
REQ-027 First request accepted on the first active edge after rst rises.

Configuration
REQ-028 Macro MEM_IO_STALL_EN: defined -> in WRITE, when latched address[17:16]==2'b11 and in_io_buffer_full=1, SHALL hold counter, drive out_ram_wr=0, retry next cycle; undefined -> in_io_buffer_full ignored, no stall.

Verification
REQ-029 SW addr 0x00001000 data 0xDEADBEEF -> writes EF@1000, BE@1001, AD@1002, DE@1003 on consecutive cycles; done pulse one cycle later.
REQ-030 SB addr 0x00000007 data 0x12345678 -> single write 78@0007; done 2 cycles after request edge.
REQ-031 SH addr 0xFFFFFFFF data 0x0000ABCD -> CD@FFFFFFFF, AB@00000000.
REQ-032 SW addr 0x00030000 with in_io_buffer_full high 3 cycles (MEM_IO_STALL_EN) -> no write for 3 cycles, then 4 bytes; undefined -> no stall.
REQ-033 rdy low 2 cycles after byte 1 of SW -> bytes 0-3 each written once, done delayed 2 cycles; rst=0 during byte 2 -> out_ram_wr 0 at once, no done.
REQ-034 size 3 request -> zero RAM writes, done pulse 1 cycle after request edge; second request during WRITE ignored.
